// File: rtl/aes_ctrl_pkg.sv
// ============================================================================
// Module      : aes_ctrl_pkg
// Description : Shared encodings for the AES round controller: FSM states,
//               key length codes, round-type codes and round counts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_KEYWAIT = 3'd1;
    localparam state_t S_LOAD    = 3'd2;
    localparam state_t S_ROUND   = 3'd3;
    localparam state_t S_LAST    = 3'd4;
    localparam state_t S_DONE    = 3'd5;

    localparam logic [1:0] KL_128  = 2'b00;
    localparam logic [1:0] KL_192  = 2'b01;
    localparam logic [1:0] KL_256  = 2'b10;
    localparam logic [1:0] KL_RSVD = 2'b11;

    localparam logic [1:0] RT_INIT  = 2'b00;
    localparam logic [1:0] RT_MID   = 2'b01;
    localparam logic [1:0] RT_FINAL = 2'b10;
    localparam logic [1:0] RT_DONE  = 2'b11;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_192:  nr_of = NR_192;
            KL_256:  nr_of = NR_256;
            default: nr_of = NR_128;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round_cnt.sv
// ============================================================================
// Module      : aes_round_cnt
// Description : Round index counter with load, up/down step, hold and a
//               terminal-value compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         down,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] cnt,
    output logic         at_term
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = down ? (cnt_q - W'(1)) : (cnt_q + W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign at_term = (cnt_q == term_val);

endmodule

`default_nettype wire

// File: rtl/aes_round_ctrl.sv
// ============================================================================
// Module      : aes_round_ctrl
// Description : AES round sequencing FSM. Optional macro AES_DECRYPT_EN adds
//               a decrypt input that makes the round index count down.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_ctrl #(
    parameter int RIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        key_len,
`ifdef AES_DECRYPT_EN
    input  logic              decrypt,
`endif
    input  logic              data_stable,
    input  logic              key_ready,
    input  logic              dp_ready,
    input  logic              abort,
    output logic              busy,
    output logic              key_req,
    output logic [1:0]        round_type_sel,
    output logic [RIDX_W-1:0] round_index,
    output logic              finished,
    output logic              cfg_err
);

    import aes_ctrl_pkg::*;

    state_t            state_q, state_d;
    logic [3:0]        nr_q, nr_d;
    logic              dec_q, dec_d;
    logic              cfg_err_q, cfg_err_d;

    logic              w_cnt_load;
    logic [RIDX_W-1:0] w_cnt_load_val;
    logic              w_cnt_en;
    logic [RIDX_W-1:0] w_nr_ext;
    logic [RIDX_W-1:0] w_term_val;
    logic              w_at_term;

    assign w_nr_ext   = RIDX_W'(nr_q);
    // Forward runs stop one short of nr; reverse runs stop at 1 so LAST lands on 0.
    assign w_term_val = dec_q ? RIDX_W'(1) : (w_nr_ext - RIDX_W'(1));

    always_comb begin
        state_d        = state_q;
        nr_d           = nr_q;
        dec_d          = dec_q;
        cfg_err_d      = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_en       = 1'b0;

        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            w_cnt_load = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && data_stable) begin
                        if (key_len == KL_RSVD) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            nr_d    = nr_of(key_len);
`ifdef AES_DECRYPT_EN
                            dec_d   = decrypt;
`else
                            dec_d   = 1'b0;
`endif
                            state_d = S_KEYWAIT;
                        end
                    end
                end
                S_KEYWAIT: begin
                    if (key_ready) begin
                        state_d        = S_LOAD;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = dec_q ? w_nr_ext : '0;
                    end
                end
                S_LOAD: begin
                    if (dp_ready) begin
                        state_d  = S_ROUND;
                        w_cnt_en = 1'b1;
                    end
                end
                S_ROUND: begin
                    if (dp_ready) begin
                        w_cnt_en = 1'b1;
                        if (w_at_term) begin
                            state_d = S_LAST;
                        end
                    end
                end
                S_LAST: begin
                    if (dp_ready) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d    = S_IDLE;
                    w_cnt_load = 1'b1;
                end
                default: begin
                    state_d    = S_IDLE;
                    w_cnt_load = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            nr_q      <= NR_128;
            dec_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nr_q      <= nr_d;
            dec_q     <= dec_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    aes_round_cnt #(
        .W (RIDX_W)
    ) u_round_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .load_val (w_cnt_load_val),
        .en       (w_cnt_en),
        .down     (dec_q),
        .term_val (w_term_val),
        .cnt      (round_index),
        .at_term  (w_at_term)
    );

    always_comb begin
        case (state_q)
            S_ROUND: round_type_sel = RT_MID;
            S_LAST:  round_type_sel = RT_FINAL;
            S_DONE:  round_type_sel = RT_DONE;
            default: round_type_sel = RT_INIT;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign key_req  = (state_q == S_KEYWAIT);
    assign finished = (state_q == S_DONE);
    assign cfg_err  = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
// ============================================================================
// Module      : tb_aes_round_ctrl
// Description : Directed self-checking bench for aes_round_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] key_len = 2'b00;
`ifdef AES_DECRYPT_EN
    logic       decrypt = 1'b0;
`endif
    logic       data_stable = 1'b0;
    logic       key_ready = 1'b0;
    logic       dp_ready = 1'b0;
    logic       abort = 1'b0;
    logic       busy;
    logic       key_req;
    logic [1:0] round_type_sel;
    logic [3:0] round_index;
    logic       finished;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;
    int fin_cnt = 0;

    aes_round_ctrl #(.RIDX_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .key_len        (key_len),
`ifdef AES_DECRYPT_EN
        .decrypt        (decrypt),
`endif
        .data_stable    (data_stable),
        .key_ready      (key_ready),
        .dp_ready       (dp_ready),
        .abort          (abort),
        .busy           (busy),
        .key_req        (key_req),
        .round_type_sel (round_type_sel),
        .round_index    (round_index),
        .finished       (finished),
        .cfg_err        (cfg_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (finished) fin_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_idx"}, 32'(round_index), 0);
        check({tag, "_rts"}, 32'(round_type_sel), 0);
        check({tag, "_fin"}, 32'(finished), 0);
    endtask

    // One block operation; expected sequence follows the round schedule for nr.
    task automatic run_op(input logic [1:0] kl, input int nr, input bit toggle, input bit dec);
        int phase;
        int e_idx;
        int f0;
        bit adv;
        f0 = fin_cnt;
        key_ready = 1'b1;
        dp_ready = 1'b1;
        data_stable = 1'b1;
        start = 1'b1;
        key_len = kl;
`ifdef AES_DECRYPT_EN
        decrypt = dec;
`endif
        tick();
        start = 1'b0;
        key_len = ~kl;
        check("kw_busy", 32'(busy), 1);
        check("kw_req", 32'(key_req), 1);
        check("kw_idx", 32'(round_index), 0);
        tick();
        e_idx = dec ? nr : 0;
        check("load_req", 32'(key_req), 0);
        check("load_rts", 32'(round_type_sel), 0);
        check("load_idx", 32'(round_index), 32'(e_idx));
        phase = 0;
        for (int e = 2; e < 100 && phase != 3; e++) begin
            adv = toggle ? (e % 2 == 0) : 1'b1;
            dp_ready = adv;
            tick();
            if (adv) begin
                case (phase)
                    0: begin phase = 1; e_idx = dec ? nr - 1 : 1; end
                    1: begin
                        if (e_idx == (dec ? 1 : nr - 1)) begin
                            phase = 2;
                            e_idx = dec ? 0 : nr;
                        end else begin
                            e_idx = dec ? e_idx - 1 : e_idx + 1;
                        end
                    end
                    default: phase = 3;
                endcase
            end
            check("step_idx", 32'(round_index), 32'(e_idx));
            check("step_rts", 32'(round_type_sel), 32'(phase));
            check("step_fin", 32'(finished), (phase == 3) ? 1 : 0);
            if (!toggle && phase == 3) check("latency", 32'(e), 32'(nr + 2));
        end
        dp_ready = 1'b1;
        tick();
        check_idle("post");
        check("fin_once", 32'(fin_cnt - f0), 1);
    endtask

    initial begin
        int f0;
        tick();
        tick();
        check_idle("rst");
        check("rst_req", 32'(key_req), 0);
        check("rst_cfg", 32'(cfg_err), 0);
        rst = 1'b0;

        // start without data_stable is ignored
        start = 1'b1;
        tick();
        check("nods_busy", 32'(busy), 0);

        // reserved key length
        data_stable = 1'b1;
        key_len = 2'b11;
        tick();
        start = 1'b0;
        check("cfg_pulse", 32'(cfg_err), 1);
        check("cfg_busy", 32'(busy), 0);
        tick();
        check("cfg_clear", 32'(cfg_err), 0);
        check("cfg_busy2", 32'(busy), 0);

        run_op(2'b00, 10, 1'b0, 1'b0);
        run_op(2'b10, 14, 1'b1, 1'b0);

        // abort in ROUND at index 5
        f0 = fin_cnt;
        key_len = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("ab_idx5", 32'(round_index), 5);
        check("ab_rts", 32'(round_type_sel), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort");
        tick();
        tick();
        check("ab_nofin", 32'(fin_cnt - f0), 0);

        // reset in LAST, then a fresh AES-192 run
        f0 = fin_cnt;
        start = 1'b1;
        key_len = 2'b00;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        check("rl_rts", 32'(round_type_sel), 2);
        check("rl_idx", 32'(round_index), 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rstlast");
        tick();
        check("rl_nofin", 32'(fin_cnt - f0), 0);
        run_op(2'b01, 12, 1'b0, 1'b0);

`ifdef AES_DECRYPT_EN
        run_op(2'b00, 10, 1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 The block SHALL have one parameter: RIDX_W, default 4, width of round_index; it SHALL be at least 4.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: reset; it is synchronous and active-high.
REQ-004 Port start SHALL be an input, 1 bit wide: request to begin one block operation.
REQ-005 Port key_len SHALL be an input, 2 bits wide: 00=AES-128 (nr=10), 01=AES-192 (nr=12), 10=AES-256 (nr=14), 11=reserved.
REQ-006 Port data_stable SHALL be an input, 1 bit wide: input data valid; qualifies start.
REQ-007 Port key_ready SHALL be an input, 1 bit wide: round key for the current step is available.
REQ-008 Port dp_ready SHALL be an input, 1 bit wide: datapath has completed the current round step; advance permitted.
REQ-009 Port abort SHALL be an input, 1 bit wide: cancel the operation in progress.
REQ-010 Port busy SHALL be an output, 1 bit wide: high in every state except IDLE.
REQ-011 Port key_req SHALL be an output, 1 bit wide: high only in KEYWAIT.
REQ-012 Port round_type_sel SHALL be an output, 2 bits wide: 00=initial AddRoundKey, 01=middle round, 10=final round, 11=done.
REQ-013 Port round_index SHALL be an output, RIDX_W bits wide: current round number.
REQ-014 Port finished SHALL be an output, 1 bit wide: one-cycle pulse when the operation completes; equals round_type_sel==11.
REQ-015 Port cfg_err SHALL be an output, 1 bit wide: one-cycle pulse when start is rejected for key_len=11.

Function
REQ-016 The FSM SHALL have the states IDLE, KEYWAIT, LOAD, ROUND, LAST and DONE.
REQ-017 In IDLE, start&&data_stable with key_len!=11 SHALL latch nr and move to KEYWAIT; start while data_stable=0 SHALL be ignored.
REQ-018 In IDLE, start&&data_stable with key_len=11 SHALL pulse cfg_err for one cycle and leave the FSM in IDLE.
REQ-019 KEYWAIT SHALL move to LOAD on key_req&&key_ready, with round_index=0 and round_type_sel=00.
REQ-020 LOAD SHALL move to ROUND on dp_ready, with round_index=1.
REQ-021 ROUND (round_type_sel=01) SHALL increment round_index on each dp_ready; at round_index==nr-1 with dp_ready it SHALL move to LAST with round_index=nr.
REQ-022 LAST (round_type_sel=10) SHALL move to DONE on dp_ready.
REQ-023 DONE SHALL last exactly one cycle, pulse finished, hold round_index=nr, and then return to IDLE.
REQ-024 Whenever dp_ready=0, the state and round_index SHALL hold; there is no timeout.
REQ-025 start asserted while busy SHALL be ignored; key_len SHALL be sampled only at acceptance, so changes mid-operation have no effect.
REQ-026 abort in any non-IDLE state SHALL return the FSM to IDLE on the next edge with round_index=0 and no finished pulse; abort SHALL take priority over dp_ready and key_ready.
REQ-027 Latency with key_ready=dp_ready=1 SHALL be: finished observed nr+2 edges after the start-sampling edge (12 for AES-128, 14 for AES-192, 16 for AES-256).
REQ-028 In IDLE, round_type_sel SHALL be 00 and round_index SHALL be 0.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, round_index=0, round_type_sel=00, and busy/key_req/finished/cfg_err=0.
REQ-030 rst SHALL override abort, start and all handshakes, and SHALL take effect mid-operation with no finished pulse.

Configuration
REQ-031 Macro AES_DECRYPT_EN SHALL add a 1-bit input decrypt, sampled with key_len at start acceptance.
REQ-032 With AES_DECRYPT_EN and decrypt=1: LOAD SHALL use round_index=nr, ROUND SHALL decrement round_index, the ROUND->LAST transition SHALL occur at round_index==1 with dp_ready, LAST SHALL use round_index=0, and DONE SHALL hold round_index=0.
REQ-033 Without AES_DECRYPT_EN, the decrypt port SHALL be absent and the block SHALL be encrypt-only per REQ-019..023.

Structure
REQ-034 Package aes_ctrl_pkg SHALL hold the state enum, the key_len encodings, the round_type_sel encodings and the NR_128/NR_192/NR_256 constants.
REQ-035 Sub-module aes_round_cnt SHALL implement round_index: load value, inc/dec enable, hold, and terminal-compare output; it is instanced once.

Verification
REQ-036 With key_len=00, key_ready=dp_ready=1 and a start pulse: round_index SHALL step 0,1..10, and finished SHALL pulse at edge 12 with round_index=10.
REQ-037 With key_len=10 and dp_ready toggling 1/0: the bench SHALL see 14 rounds, each stalled step held, and finished exactly once.
REQ-038 With key_len=11 and start: cfg_err SHALL pulse once and busy SHALL stay 0.
REQ-039 abort asserted in ROUND at round_index=5: the FSM SHALL be in IDLE next cycle with round_index=0, and finished SHALL never assert.
REQ-040 rst asserted in LAST, then start again with key_len=01: a clean 12-round run SHALL follow, and no finished from the first run.
REQ-041 With AES_DECRYPT_EN, decrypt=1 and key_len=00: round_index SHALL count 10..0, and finished SHALL pulse with round_index=0.
